// File: rtl/lzc_pkg.sv
// Shared constants, types and helpers for the pipelined leading-zero counter.
// The pair encoder and stage-offset helpers are used by the RTL; lzc_ref is the golden count.
package lzc_pkg;

  localparam int LZC_WIDTH  = 32;
  localparam int LZC_LEVELS = $clog2(LZC_WIDTH);

  typedef logic [LZC_LEVELS:0] lzc_count_t;

  // Pair encoder: MSB is the all-zero flag, LSB is the count within the pair.
  function automatic logic [1:0] lzc_enc2(input logic [1:0] p);
    logic [1:0] r;
    r = 2'b10;
    if (p[1])      r = 2'b00;
    else if (p[0]) r = 2'b01;
    return r;
  endfunction

  // Bit offset of a stage inside the flattened stage bus; stage s holds
  // width>>(s+1) nodes of s+2 bits each.
  function automatic int lzc_stage_off(input int width, input int stage);
    int s;
    s = 0;
    for (int j = 0; j < stage; j++) s += (width >> (j + 1)) * (j + 2);
    return s;
  endfunction

  function automatic lzc_count_t lzc_ref(input logic [LZC_WIDTH-1:0] w);
    lzc_count_t n;
    logic       found;
    n     = '0;
    found = 1'b0;
    for (int i = LZC_WIDTH - 1; i >= 0; i--) begin
      if (!found) begin
        if (w[i]) found = 1'b1;
        else       n = n + lzc_count_t'(1);
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/lzc_level.sv
// One merge level of the leading-zero tree: N_IN/2 combinational nodes feeding
// a register bank and a valid bit, both enabled by the global advance.
module lzc_level #(
  parameter int N_IN = 2,
  parameter int W_IN = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             adv,
  input  logic                             in_v,
  input  logic [N_IN*W_IN-1:0]             in_d,
  output logic                             out_v,
  output logic [(N_IN/2)*(W_IN+1)-1:0]     out_d
);

  localparam int N_OUT = N_IN / 2;
  localparam int W_OUT = W_IN + 1;

  logic [N_OUT*W_OUT-1:0] nxt;

  // Node MSB is the all-zero flag; a non-zero high half decides the count alone.
  for (genvar k = 0; k < N_OUT; k++) begin : g_node
    logic [W_IN-1:0] hi;
    logic [W_IN-1:0] lo;
    assign hi = in_d[(2*k+1)*W_IN +: W_IN];
    assign lo = in_d[(2*k)*W_IN +: W_IN];
    assign nxt[k*W_OUT +: W_OUT] = hi[W_IN-1]
      ? {hi[W_IN-1] & lo[W_IN-1], ~lo[W_IN-1], lo[W_IN-2:0]}
      : {2'b00, hi[W_IN-2:0]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_d <= '0;
      out_v <= 1'b0;
    end else if (adv) begin
      out_d <= nxt;
      out_v <= in_v;
    end
  end

endmodule

// File: rtl/lzc_pipe.sv
// Pipelined leading-zero counter: pair-encode stage followed by LEVELS-1 merge
// stages, one register stage per tree level, under a single global stall.
module lzc_pipe
  import lzc_pkg::*;
#(
  parameter  int WIDTH  = LZC_WIDTH,
  localparam int LEVELS = $clog2(WIDTH),
  localparam int CW     = LEVELS + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             busy
);

  localparam int TOT = lzc_stage_off(WIDTH, LEVELS);

  // Handshake: a word transfers on any edge with valid & ready on that side.
  // Every stage advances together when the output is empty or being taken,
  // so in_ready is that same advance enable and bubbles are never squeezed out.
  logic              adv;
  logic [LEVELS-1:0] vbits;
  logic [TOT-1:0]    sbus;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  for (genvar i = 0; i < LEVELS; i++) begin : g_stage
    localparam int OFF  = lzc_stage_off(WIDTH, i);
    localparam int NOUT = (WIDTH >> (i + 1)) * (i + 2);

    if (i == 0) begin : g_enc
      logic [NOUT-1:0] enc_d;
      logic [NOUT-1:0] enc_q;
      logic            enc_v;

      for (genvar k = 0; k < WIDTH / 2; k++) begin : g_pair
        assign enc_d[2*k +: 2] = lzc_enc2(in_data[2*k +: 2]);
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          enc_q <= '0;
          enc_v <= 1'b0;
        end else if (adv) begin
          enc_q <= enc_d;
          enc_v <= in_valid;
        end
      end

      assign sbus[OFF +: NOUT] = enc_q;
      assign vbits[0]          = enc_v;
    end else begin : g_mrg
      localparam int PREV_OFF = lzc_stage_off(WIDTH, i - 1);
      localparam int PREV_N   = (WIDTH >> i) * (i + 1);

      lzc_level #(
        .N_IN (WIDTH >> i),
        .W_IN (i + 1)
      ) u_level (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (adv),
        .in_v  (vbits[i-1]),
        .in_d  (sbus[PREV_OFF +: PREV_N]),
        .out_v (vbits[i]),
        .out_d (sbus[OFF +: NOUT])
      );
    end
  end

  assign out_valid = vbits[LEVELS-1];
  assign out_count = sbus[lzc_stage_off(WIDTH, LEVELS - 1) +: CW];
  assign busy      = |vbits;

endmodule

// File: tb/tb_lzc_pipe.sv
// Directed bench for lzc_pipe: scoreboard queue of expected counts fed at
// accept time, a per-cycle compare process, and hand-computed literal checks.
module tb_lzc_pipe;

  localparam int W  = 32;
  localparam int CW = 6;
  localparam int LAT = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_count;
  logic          busy;

  int errors = 0;
  int checks = 0;
  logic [CW-1:0] exp_q[$];

  always #5 clk = ~clk;

  lzc_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .busy      (busy)
  );

  // Leading zeros by shifting left until the top bit is set.
  function automatic int lz_model(input logic [W-1:0] w);
    logic [W-1:0] v;
    int n;
    v = w;
    n = 0;
    while (n < W && v < 32'h8000_0000) begin
      v = v << 1;
      n++;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Compare process: runs every cycle on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      chk("in_ready_rule", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
      chk("busy_vs_inflight", {31'b0, busy}, {31'b0, (exp_q.size() != 0)});
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got count %0d expected no output at %0t", out_count, $time);
        end else begin
          chk("out_count", {26'b0, out_count}, {26'b0, exp_q[0]});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(CW'(lz_model(in_data)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 50) begin
      step();
      n++;
    end
    chk("drain_bound", {31'b0, (n < 50)}, 32'd1);
  endtask

  task automatic single(input logic [W-1:0] w, input int exp);
    int n;
    in_valid = 1'b1;
    in_data  = w;
    step();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk("latency", n, LAT);
    chk("single_count", {26'b0, out_count}, exp);
    step();
  endtask

  initial begin
    int n;
    logic [W-1:0] bp_words [2];
    logic [W-1:0] fill_words [6];

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_out_count", {26'b0, out_count}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    step();

    chk("model_msb", lz_model(32'h8000_0000), 0);
    chk("model_zero", lz_model(32'h0000_0000), 32);
    chk("model_0100", lz_model(32'h0100_0000), 7);

    // Singles
    single(32'h8000_0000, 0);
    single(32'h0000_0001, 31);
    single(32'h0000_0000, 32);
    single(32'h0000_FFFF, 16);
    drain();

    // Back-to-back random stream
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom() >> $urandom_range(0, 32);
      @(negedge clk);
      chk("stream_in_ready", {31'b0, in_ready}, 1);
      step();
    end
    in_valid = 1'b0;
    drain();

    // Fill the pipe under stall, then consume and accept on the same edge
    fill_words[0] = 32'h4000_0000; fill_words[1] = 32'h0000_0400;
    fill_words[2] = 32'h0020_0000; fill_words[3] = 32'h0000_0003;
    fill_words[4] = 32'h1000_0000; fill_words[5] = 32'h0000_0010;
    out_ready = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      in_valid = 1'b1;
      in_data  = fill_words[i];
      @(negedge clk);
      chk("fill_in_ready", {31'b0, in_ready}, 1);
      step();
    end
    chk("full_out_valid", {31'b0, out_valid}, 1);
    chk("full_in_ready", {31'b0, in_ready}, 0);
    chk("full_head", {26'b0, out_count}, 1);
    in_data   = fill_words[5];
    out_ready = 1'b1;
    @(negedge clk);
    chk("sim_accept_ready", {31'b0, in_ready}, 1);
    step();
    in_valid = 1'b0;
    chk("sim_next_count", {26'b0, out_count}, 21);
    drain();

    // Backpressure
    bp_words[0] = 32'h0100_0000;
    bp_words[1] = 32'h0000_0080;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = bp_words[i];
      step();
    end
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk("bp_arrive", {31'b0, out_valid}, 1);
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom();
      @(negedge clk);
      chk("bp_hold_count", {26'b0, out_count}, 7);
      chk("bp_hold_valid", {31'b0, out_valid}, 1);
      chk("bp_in_ready", {31'b0, in_ready}, 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release_valid", {31'b0, out_valid}, 1);
    chk("bp_release_count", {26'b0, out_count}, 24);
    drain();

    // Bubbles
    for (int c = 0; c < 24; c++) begin
      int j;
      logic ev;
      in_valid = (c < 16) && (c % 2 == 0);
      in_data  = ((c / 2) % 2 == 0) ? 32'hFFFF_FFFF : 32'h0000_0002;
      j  = c - LAT;
      ev = (j >= 0) && (j < 16) && (j % 2 == 0);
      @(negedge clk);
      chk("bubble_valid", {31'b0, out_valid}, {31'b0, ev});
      if (ev) chk("bubble_count", {26'b0, out_count}, ((j / 2) % 2 == 0) ? 0 : 30);
      step();
    end
    in_valid = 1'b0;
    drain();

    // Reset mid-flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h0000_0100 << i;
      step();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      chk("mid_rst_out_valid", {31'b0, out_valid}, 0);
      chk("mid_rst_busy", {31'b0, busy}, 0);
      chk("mid_rst_in_ready", {31'b0, in_ready}, 1);
      step();
    end
    single(32'h0000_8000, 16);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
